spiker_frame_sequencer: RTL and testbench

Sequences one spike frame into the spiker core as a stream of CHUNK_W-bit beats and replays it for a programmed number of timesteps. It sits between the register-file front end (frame, start, step count) and the spiker core (sample handshake, per-timestep start/done). It raises done and interrupt status when the run completes. It latches the frame at start, so software may rewrite the spike registers while a run is in progress.

---
 rtl/spiker_adapter_pkg.sv | 12 +
 rtl/spiker_chunk_shifter.sv | 28 ++
 rtl/spiker_frame_sequencer.sv | 148 ++++++++++++++
 tb/tb_spiker_frame_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spiker_adapter_pkg.sv
// Shared types for the spiker adapter: frame sequencer state encoding.
package spiker_adapter_pkg;

   typedef enum logic [2:0] {
      SEQ_IDLE      = 3'd0,
      SEQ_LOAD      = 3'd1,
      SEQ_STREAM    = 3'd2,
      SEQ_WAIT_CORE = 3'd3,
      SEQ_DONE      = 3'd4
   } seq_state_t;

endpackage

// File: rtl/spiker_chunk_shifter.sv
// Loadable left-shift register presenting the top CHUNK_W bits as the current beat.
module spiker_chunk_shifter #(
   parameter int DATA_WIDTH = 800,
   parameter int CHUNK_W    = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  load_i,
   input  logic                  shift_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [CHUNK_W-1:0]    chunk_o
);

   logic [DATA_WIDTH-1:0] shift_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shift_q <= '0;
      end else if (load_i) begin
         shift_q <= data_i;
      end else if (shift_i) begin
         shift_q <= shift_q << CHUNK_W;
      end
   end

   assign chunk_o = shift_q[DATA_WIDTH-1 -: CHUNK_W];

endmodule

// File: rtl/spiker_frame_sequencer.sv
// Streams a latched spike frame into the spiker core as CHUNK_W-bit beats,
// replaying it once per timestep until the programmed step count is reached.
module spiker_frame_sequencer
   import spiker_adapter_pkg::*;
#(
   parameter int DATA_WIDTH = 800,
   parameter int CHUNK_W    = 4,
   parameter int STEP_W     = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [DATA_WIDTH-1:0] frame_i,
   input  logic [STEP_W-1:0]     n_steps_i,
   output logic [CHUNK_W-1:0]    chunk_o,
   output logic                  chunk_valid_o,
   input  logic                  chunk_ready_i,
   output logic                  step_start_o,
   input  logic                  step_done_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  aborted_o,
   output logic                  irq_o,
   output logic [STEP_W-1:0]     step_cnt_o
);

   localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_W;
   localparam int BEAT_W     = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_CHUNKS - 1);

   if (DATA_WIDTH % CHUNK_W != 0) begin : g_bad_chunk_w
      $fatal(1, "DATA_WIDTH must be a multiple of CHUNK_W");
   end

   seq_state_t            state_q;
   logic [DATA_WIDTH-1:0] frame_q;
   logic [STEP_W-1:0]     steps_q;
   logic [STEP_W-1:0]     step_cnt;
   logic [STEP_W-1:0]     step_next;
   logic [BEAT_W-1:0]     beat_cnt;

   assign step_next  = step_cnt + STEP_W'(1);
   assign step_cnt_o = step_cnt;

   spiker_chunk_shifter #(
      .DATA_WIDTH (DATA_WIDTH),
      .CHUNK_W    (CHUNK_W)
   ) u_shifter (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (state_q == SEQ_LOAD),
      .shift_i (chunk_valid_o && chunk_ready_i),
      .data_i  (frame_q),
      .chunk_o (chunk_o)
   );

   // Outputs are registered alongside the state so they line up with the state they describe.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= SEQ_IDLE;
         frame_q       <= '0;
         steps_q       <= '0;
         step_cnt      <= '0;
         beat_cnt      <= '0;
         chunk_valid_o <= 1'b0;
         step_start_o  <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         aborted_o     <= 1'b0;
         irq_o         <= 1'b0;
      end else begin
         step_start_o <= 1'b0;
         irq_o        <= 1'b0;
         unique case (state_q)
            SEQ_IDLE: begin
               if (start_i && !abort_i) begin
                  done_o    <= 1'b0;
                  aborted_o <= 1'b0;
                  busy_o    <= 1'b1;
                  if (n_steps_i != '0) begin
                     frame_q      <= frame_i;
                     steps_q      <= n_steps_i;
                     step_cnt     <= '0;
                     step_start_o <= 1'b1;
                     state_q      <= SEQ_LOAD;
                  end else begin
                     irq_o   <= 1'b1;
                     state_q <= SEQ_DONE;
                  end
               end
            end
            SEQ_LOAD: begin
               beat_cnt <= '0;
               if (abort_i) begin
                  aborted_o <= 1'b1;
                  busy_o    <= 1'b0;
                  state_q   <= SEQ_IDLE;
               end else begin
                  chunk_valid_o <= 1'b1;
                  state_q       <= SEQ_STREAM;
               end
            end
            SEQ_STREAM: begin
               if (chunk_ready_i) begin
                  beat_cnt <= beat_cnt + BEAT_W'(1);
               end
               if (abort_i) begin
                  aborted_o     <= 1'b1;
                  busy_o        <= 1'b0;
                  chunk_valid_o <= 1'b0;
                  state_q       <= SEQ_IDLE;
               end else if (chunk_ready_i && (beat_cnt == LAST_BEAT)) begin
                  chunk_valid_o <= 1'b0;
                  state_q       <= SEQ_WAIT_CORE;
               end
            end
            SEQ_WAIT_CORE: begin
               if (abort_i) begin
                  aborted_o <= 1'b1;
                  busy_o    <= 1'b0;
                  state_q   <= SEQ_IDLE;
               end else if (step_done_i) begin
                  step_cnt <= step_next;
                  if (step_next == steps_q) begin
                     irq_o   <= 1'b1;
                     state_q <= SEQ_DONE;
                  end else begin
                     step_start_o <= 1'b1;
                     state_q      <= SEQ_LOAD;
                  end
               end
            end
            SEQ_DONE: begin
               done_o  <= 1'b1;
               busy_o  <= 1'b0;
               state_q <= SEQ_IDLE;
            end
            default: begin
               busy_o        <= 1'b0;
               chunk_valid_o <= 1'b0;
               state_q       <= SEQ_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spiker_frame_sequencer.sv
// Directed self-checking bench for spiker_frame_sequencer: runs, replay, backpressure,
// zero steps, aborts, start-while-busy and asynchronous reset.
module tb_spiker_frame_sequencer;

   localparam int DW = 800;
   localparam int CW = 4;
   localparam int NC = DW / CW;
   localparam int SW = 16;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic [DW-1:0] frame_i = '0;
   logic [SW-1:0] n_steps_i = '0;
   logic [CW-1:0] chunk_o;
   logic          chunk_valid_o;
   logic          chunk_ready_i = 1'b0;
   logic          step_start_o;
   logic          step_done_i = 1'b0;
   logic          busy_o;
   logic          done_o;
   logic          aborted_o;
   logic          irq_o;
   logic [SW-1:0] step_cnt_o;

   int errors = 0;
   int checks = 0;
   int irqCount = 0;
   int startCount = 0;

   logic [DW-1:0] frameA5;
   logic [DW-1:0] frameRep;

   spiker_frame_sequencer #(
      .DATA_WIDTH (DW),
      .CHUNK_W    (CW),
      .STEP_W     (SW)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .start_i       (start_i),
      .abort_i       (abort_i),
      .frame_i       (frame_i),
      .n_steps_i     (n_steps_i),
      .chunk_o       (chunk_o),
      .chunk_valid_o (chunk_valid_o),
      .chunk_ready_i (chunk_ready_i),
      .step_start_o  (step_start_o),
      .step_done_i   (step_done_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .aborted_o     (aborted_o),
      .irq_o         (irq_o),
      .step_cnt_o    (step_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (irq_o) irqCount++;
      if (step_start_o) startCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [CW-1:0] expBeat(input logic [DW-1:0] f, input int k);
      return f[DW-1-CW*k -: CW];
   endfunction

   task automatic applyStimulus(input logic [DW-1:0] f, input logic [SW-1:0] n);
      frame_i   = f;
      n_steps_i = n;
      start_i   = 1'b1;
      tick();
      start_i   = 1'b0;
   endtask

   // Called while the LOAD cycle is observed; returns once stopAfter beats have been handed over.
   task automatic runStep(input logic [DW-1:0] f, input int mode, input int stopAfter,
                          output int beats, output int errs);
      logic          r;
      logic          prevStall;
      logic [CW-1:0] held;
      beats = 0;
      errs = 0;
      prevStall = 1'b0;
      held = '0;
      for (int cyc = 0; cyc < 2000 && beats < stopAfter; cyc++) begin
         tick();
         r = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         if (chunk_valid_o) begin
            if (prevStall && chunk_o != held) errs++;
            if (r) begin
               if (chunk_o != expBeat(f, beats)) errs++;
               beats++;
            end
            prevStall = !r;
            held = chunk_o;
         end else begin
            errs++;
         end
         chunk_ready_i = r;
      end
   endtask

   task automatic doRun(input string tag, input logic [DW-1:0] f, input int n, input int mode,
                        input logic holdStart);
      int beats, errs, irq0, st0;
      irq0 = irqCount;
      st0 = startCount;
      applyStimulus(f, SW'(n));
      frame_i   = ~f;
      n_steps_i = SW'(n + 5);
      start_i   = holdStart;
      for (int s = 0; s < n; s++) begin
         checkOutput({tag, "_step_start"}, 32'(step_start_o), 32'd1);
         checkOutput({tag, "_step_cnt_mid"}, 32'(step_cnt_o), 32'(s));
         runStep(f, mode, NC, beats, errs);
         checkOutput({tag, "_beats"}, 32'(beats), 32'(NC));
         checkOutput({tag, "_beat_errs"}, 32'(errs), 32'd0);
         tick();
         chunk_ready_i = 1'b0;
         checkOutput({tag, "_wait_valid"}, 32'(chunk_valid_o), 32'd0);
         start_i     = 1'b0;
         step_done_i = 1'b1;
         tick();
         step_done_i = 1'b0;
      end
      checkOutput({tag, "_irq"}, 32'(irq_o), 32'd1);
      checkOutput({tag, "_done_in_done"}, 32'(done_o), 32'd0);
      tick();
      checkOutput({tag, "_done"}, 32'(done_o), 32'd1);
      checkOutput({tag, "_busy_end"}, 32'(busy_o), 32'd0);
      checkOutput({tag, "_step_cnt"}, 32'(step_cnt_o), 32'(n));
      tick();
      checkOutput({tag, "_irq_pulses"}, 32'(irqCount - irq0), 32'd1);
      checkOutput({tag, "_start_pulses"}, 32'(startCount - st0), 32'(n));
   endtask

   initial begin
      int beats, errs, irq0, st0;
      frameA5 = '0;
      frameA5[DW-1 -: 8] = 8'hA5;
      frameRep = {25{32'h1234_5678}};

      tick();
      tick();
      checkOutput("rst_busy", 32'(busy_o), 32'd0);
      checkOutput("rst_valid", 32'(chunk_valid_o), 32'd0);
      checkOutput("rst_done", 32'(done_o), 32'd0);
      checkOutput("rst_irq", 32'(irq_o), 32'd0);
      checkOutput("rst_step_cnt", 32'(step_cnt_o), 32'd0);
      checkOutput("rst_chunk", 32'(chunk_o), 32'd0);
      #2 rst_ni = 1'b1;
      tick();

      doRun("basic", frameA5, 1, 0, 1'b0);
      doRun("replay", frameRep, 3, 0, 1'b0);
      doRun("backpressure", frameRep, 1, 1, 1'b0);

      irq0 = irqCount;
      st0 = startCount;
      applyStimulus(frameA5, '0);
      checkOutput("zero_irq", 32'(irq_o), 32'd1);
      checkOutput("zero_done_cleared", 32'(done_o), 32'd0);
      checkOutput("zero_busy", 32'(busy_o), 32'd1);
      tick();
      checkOutput("zero_done", 32'(done_o), 32'd1);
      checkOutput("zero_busy_end", 32'(busy_o), 32'd0);
      checkOutput("zero_start_pulses", 32'(startCount - st0), 32'd0);
      checkOutput("zero_irq_pulses", 32'(irqCount - irq0), 32'd1);

      irq0 = irqCount;
      applyStimulus(frameRep, 16'd1);
      runStep(frameRep, 0, 57, beats, errs);
      checkOutput("abort_beats", 32'(beats), 32'd57);
      tick();
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      chunk_ready_i = 1'b0;
      checkOutput("abort_valid", 32'(chunk_valid_o), 32'd0);
      checkOutput("abort_flag", 32'(aborted_o), 32'd1);
      checkOutput("abort_done", 32'(done_o), 32'd0);
      checkOutput("abort_busy", 32'(busy_o), 32'd0);
      tick();
      checkOutput("abort_irq_pulses", 32'(irqCount - irq0), 32'd0);
      applyStimulus(frameA5, 16'd1);
      checkOutput("restart_aborted_clr", 32'(aborted_o), 32'd0);
      runStep(frameA5, 0, NC, beats, errs);
      checkOutput("restart_beats", 32'(beats), 32'(NC));
      checkOutput("restart_errs", 32'(errs), 32'd0);
      tick();
      chunk_ready_i = 1'b0;
      step_done_i = 1'b1;
      tick();
      step_done_i = 1'b0;
      checkOutput("restart_irq", 32'(irq_o), 32'd1);
      tick();
      checkOutput("restart_done", 32'(done_o), 32'd1);

      doRun("busy_start", frameA5, 1, 0, 1'b1);

      abort_i = 1'b1;
      applyStimulus(frameRep, 16'd1);
      abort_i = 1'b0;
      checkOutput("abort_start_busy", 32'(busy_o), 32'd0);
      checkOutput("abort_start_step", 32'(step_start_o), 32'd0);

      irq0 = irqCount;
      applyStimulus(frameRep, 16'd1);
      runStep(frameRep, 0, NC, beats, errs);
      tick();
      chunk_ready_i = 1'b0;
      step_done_i = 1'b1;
      abort_i = 1'b1;
      tick();
      step_done_i = 1'b0;
      abort_i = 1'b0;
      checkOutput("abort_final_busy", 32'(busy_o), 32'd0);
      checkOutput("abort_final_flag", 32'(aborted_o), 32'd1);
      checkOutput("abort_final_done", 32'(done_o), 32'd0);
      tick();
      checkOutput("abort_final_irq_pulses", 32'(irqCount - irq0), 32'd0);

      applyStimulus(frameA5, 16'd2);
      runStep(frameA5, 0, NC, beats, errs);
      tick();
      chunk_ready_i = 1'b0;
      step_done_i = 1'b1;
      tick();
      step_done_i = 1'b0;
      runStep(frameA5, 0, NC, beats, errs);
      tick();
      chunk_ready_i = 1'b0;
      checkOutput("reset_pre_busy", 32'(busy_o), 32'd1);
      checkOutput("reset_pre_step_cnt", 32'(step_cnt_o), 32'd1);
      #2 rst_ni = 1'b0;
      #1;
      checkOutput("reset_busy", 32'(busy_o), 32'd0);
      checkOutput("reset_step_cnt", 32'(step_cnt_o), 32'd0);
      checkOutput("reset_valid", 32'(chunk_valid_o), 32'd0);
      checkOutput("reset_done", 32'(done_o), 32'd0);
      tick();
      #2 rst_ni = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
